multicycle_ctrl: RTL and testbench

//  Parametrised successor to the multicycle MIPS control FSM: Moore/Mealy controller driving the shared-memory datapath.

---
 rtl/mc_ctrl_pkg.sv | 54 +++++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle controller.
//   state_t      controller state enum (EXC only present when MC_EXC_EN is defined)
//   OPC_*        instruction opcodes decoded by the controller
//   ULA_*        ALU operation codes (3-bit, zero-extended onto the ULAOp bus)
//   PCS_*        PC source mux codes
//   is_mem_state states that issue a memory request
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
`ifdef MC_EXC_EN
    , S_EXC
`endif
  } state_t;

  localparam int unsigned OPC_RTYPE = 0;
  localparam int unsigned OPC_J     = 2;
  localparam int unsigned OPC_BEQ   = 4;
  localparam int unsigned OPC_BNE   = 5;
  localparam int unsigned OPC_ADDI  = 8;
  localparam int unsigned OPC_SLTI  = 10;
  localparam int unsigned OPC_ANDI  = 12;
  localparam int unsigned OPC_ORI   = 13;
  localparam int unsigned OPC_LW    = 35;
  localparam int unsigned OPC_SW    = 43;

  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;
  localparam logic [2:0] ULA_FUNCT = 3'b010;
  localparam logic [2:0] ULA_AND   = 3'b011;
  localparam logic [2:0] ULA_OR    = 3'b100;
  localparam logic [2:0] ULA_SLT   = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts wait cycles of the current memory access and flags
// the cycle on which the access has waited TIMEOUT_CYC cycles.
//   clk, reset  clock, asynchronous active-high reset
//   clr         restart the count (new access / access finished)
//   wait_en     access pending and memory not ready this cycle ("wait" is reserved)
//   expired     this cycle is the TIMEOUT_CYC-th wait cycle (never when TIMEOUT_CYC=0)
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic wait_en,
  output logic expired
);

  // cnt holds the number of wait cycles already elapsed, so the N-th wait
  // cycle sees cnt == N-1 and that is where the timeout fires.
  localparam int unsigned CW  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned LIM = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (wait_en) cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT_CYC != 0) && wait_en && (cnt == CW'(LIM));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory wait-state
// handshake and timeout. Optional illegal-opcode exception under MC_EXC_EN.
//   clk, reset       clock, asynchronous active-high reset
//   Opcode           opcode from the instruction register
//   mem_ready        memory completes the current access this cycle
//   mem_req          memory access requested
//   IorD, ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSrc, ULAOp   datapath selects
//   IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNe   write enables
//   ImmZext          zero-extend immediate (andi/ori)
//   bus_err          one-cycle pulse on memory timeout
//   exc_illegal      illegal opcode (MC_EXC_EN builds only, else 0)
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               ALUSrcA,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ULAOp,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               Branch,
  output logic               BranchNe,
  output logic               ImmZext,
  output logic               bus_err,
  output logic               exc_illegal
);

  state_t     state, nxt;
  logic       wait_en, expired, clr, zext;
  logic [2:0] ula;

  // Computed from the state register only so the timer input does not
  // depend on the decode block that consumes its output.
  assign wait_en = is_mem_state(state) & ~mem_ready;
  assign clr     = (nxt != state) | expired;
  assign zext    = (Opcode == OP_W'(OPC_ANDI)) || (Opcode == OP_W'(OPC_ORI));
  assign ULAOp   = ALUOP_W'(ula);

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .wait_en (wait_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt         = state;
    mem_req     = 1'b0;
    IorD        = 1'b0;
    ALUSrcA     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = '0;
    PCSrc       = PCS_ALU;
    ula         = ULA_ADD;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    Branch      = 1'b0;
    BranchNe    = 1'b0;
    ImmZext     = 1'b0;
    bus_err     = 1'b0;
    exc_illegal = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)    nxt = S_DECODE;
        else if (expired) begin
          bus_err = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_W'(OPC_RTYPE):                nxt = S_EXECUTE;
          OP_W'(OPC_LW), OP_W'(OPC_SW):    nxt = S_MEMADR;
          OP_W'(OPC_BEQ), OP_W'(OPC_BNE):  nxt = S_BRANCH;
          OP_W'(OPC_ADDI), OP_W'(OPC_SLTI),
          OP_W'(OPC_ANDI), OP_W'(OPC_ORI): nxt = S_IMMEX;
          OP_W'(OPC_J):                    nxt = S_JUMP;
`ifdef MC_EXC_EN
          default:                         nxt = S_EXC;
`else
          default:                         nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Opcode == OP_W'(OPC_LW))      nxt = S_MEMREAD;
        else if (Opcode == OP_W'(OPC_SW)) nxt = S_MEMWRITE;
        else                              nxt = S_FETCH;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    nxt = S_MEMWB;
        else if (expired) begin
          bus_err = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready)    nxt = S_FETCH;
        else if (expired) begin
          bus_err = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ula     = ULA_FUNCT;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ula      = ULA_SUB;
        PCSrc    = PCS_ALUOUT;
        Branch   = (Opcode == OP_W'(OPC_BEQ));
        BranchNe = (Opcode == OP_W'(OPC_BNE));
        nxt      = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ImmZext = zext;
        case (Opcode)
          OP_W'(OPC_SLTI): ula = ULA_SLT;
          OP_W'(OPC_ANDI): ula = ULA_AND;
          OP_W'(OPC_ORI):  ula = ULA_OR;
          default:         ula = ULA_ADD;
        endcase
        nxt = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        ImmZext  = zext;
        nxt      = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCS_JUMP;
        PCWrite = 1'b1;
        nxt     = S_FETCH;
      end
`ifdef MC_EXC_EN
      S_EXC: begin
        PCSrc       = PCS_EXC;
        PCWrite     = 1'b1;
        exc_illegal = 1'b1;
        nxt         = S_FETCH;
      end
`endif
      default: nxt = S_FETCH;
    endcase

    // Reset gates requests and enables combinationally so an access in
    // flight is dropped in the same cycle reset rises.
    if (reset) begin
      mem_req     = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      Branch      = 1'b0;
      BranchNe    = 1'b0;
      bus_err     = 1'b0;
      exc_illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int unsigned TO = 15;

  typedef struct packed {
    logic       mem_req, IorD, ALUSrcA, MemtoReg, RegDst;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ULAOp;
    logic       IRWrite, PCWrite, MemWrite, RegWrite;
    logic       Branch, BranchNe, ImmZext, bus_err, exc_illegal;
  } ctl_t;

  typedef struct {
    logic mr;
    ctl_t c;
  } step_t;

  logic       clk, reset, mem_ready;
  logic [5:0] Opcode;
  logic       mem_req, IorD, ALUSrcA, MemtoReg, RegDst;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ULAOp;
  logic       IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNe;
  logic       ImmZext, bus_err, exc_illegal;

  int    checks = 0;
  int    failures = 0;
  step_t q[$];
  ctl_t  seen[64];

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ULAOp(ULAOp),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .Branch(Branch), .BranchNe(BranchNe),
    .ImmZext(ImmZext), .bus_err(bus_err), .exc_illegal(exc_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic ctl_t pack_dut();
    ctl_t a;
    a.mem_req = mem_req;   a.IorD = IorD;         a.ALUSrcA = ALUSrcA;
    a.MemtoReg = MemtoReg; a.RegDst = RegDst;     a.ALUSrcB = ALUSrcB;
    a.PCSrc = PCSrc;       a.ULAOp = ULAOp;       a.IRWrite = IRWrite;
    a.PCWrite = PCWrite;   a.MemWrite = MemWrite; a.RegWrite = RegWrite;
    a.Branch = Branch;     a.BranchNe = BranchNe; a.ImmZext = ImmZext;
    a.bus_err = bus_err;   a.exc_illegal = exc_illegal;
    return a;
  endfunction

  task automatic push(input logic mr, input ctl_t c);
    step_t s;
    s.mr = mr;
    s.c  = c;
    q.push_back(s);
  endtask

  // One memory access: lat cycles without ready, then completion (with the
  // access's write enables) or, if it would wait TO cycles, a bus error.
  task automatic access(input ctl_t base, input int lat, input int en, output bit ok);
    ctl_t w;
    if (TO != 0 && lat >= int'(TO)) begin
      for (int i = 0; i < int'(TO) - 1; i++) push(1'b0, base);
      w = base;
      w.bus_err = 1'b1;
      push(1'b0, w);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < lat; i++) push(1'b0, base);
      w = base;
      if (en == 1) begin w.IRWrite = 1'b1; w.PCWrite = 1'b1; end
      if (en == 2) w.MemWrite = 1'b1;
      push(1'b1, w);
      ok = 1'b1;
    end
  endtask

  // Expected per-cycle control words of one instruction, from its class.
  task automatic gen_instr(input int op, input int flat, input int dlat);
    ctl_t w;
    bit   ok;
    w = '0; w.mem_req = 1'b1; w.ALUSrcB = 2'b01;
    access(w, flat, 1, ok);
    if (!ok) return;
    w = '0; w.ALUSrcB = 2'b11;
    push(1'b1, w);
    case (op)
      0: begin
        w = '0; w.ALUSrcA = 1'b1; w.ULAOp = 3'b010; push(1'b1, w);
        w = '0; w.RegDst = 1'b1; w.RegWrite = 1'b1; push(1'b1, w);
      end
      35, 43: begin
        w = '0; w.ALUSrcA = 1'b1; w.ALUSrcB = 2'b10; push(1'b1, w);
        w = '0; w.mem_req = 1'b1; w.IorD = 1'b1;
        access(w, dlat, (op == 43) ? 2 : 0, ok);
        if (ok && op == 35) begin
          w = '0; w.MemtoReg = 1'b1; w.RegWrite = 1'b1; push(1'b1, w);
        end
      end
      4, 5: begin
        w = '0; w.ALUSrcA = 1'b1; w.ULAOp = 3'b001; w.PCSrc = 2'b01;
        w.Branch = (op == 4); w.BranchNe = (op == 5);
        push(1'b1, w);
      end
      8, 10, 12, 13: begin
        w = '0; w.ALUSrcA = 1'b1; w.ALUSrcB = 2'b10;
        w.ULAOp = (op == 10) ? 3'b101 : (op == 12) ? 3'b011 : (op == 13) ? 3'b100 : 3'b000;
        w.ImmZext = (op >= 12);
        push(1'b1, w);
        w = '0; w.RegWrite = 1'b1; w.ImmZext = (op >= 12); push(1'b1, w);
      end
      2: begin
        w = '0; w.PCSrc = 2'b10; w.PCWrite = 1'b1; push(1'b1, w);
      end
      default: begin
`ifdef MC_EXC_EN
        w = '0; w.PCSrc = 2'b11; w.PCWrite = 1'b1; w.exc_illegal = 1'b1; push(1'b1, w);
`endif
      end
    endcase
  endtask

  // Compare process: drive each cycle's mem_ready after the edge, check at
  // the falling edge, record what the DUT showed.
  task automatic run_trace(input string tag, output int n);
    step_t s;
    ctl_t  a;
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.mr;
      @(negedge clk);
      a = pack_dut();
      chk($sformatf("%s_cyc%0d", tag, n), 32'(a), 32'(s.c));
      if (n < 64) seen[n] = a;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string tag, input int op, input int flat,
                          input int dlat, output int n);
    Opcode = 6'(op);
    gen_instr(op, flat, dlat);
    run_trace(tag, n);
  endtask

  initial begin
    int   n, cnt;
    ctl_t w;
    reset = 1'b1;
    mem_ready = 1'b1;
    Opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'({mem_req, IRWrite, PCWrite, MemWrite, RegWrite, bus_err,
                          Branch, BranchNe, exc_illegal}), 32'd0);
    reset = 1'b0;

    do_instr("add", 0, 0, 0, n);
    chk("add_wb", 32'({seen[3].RegWrite, seen[3].RegDst}), 32'b11);
    chk("add_funct", 32'(seen[2].ULAOp), 32'b010);

    do_instr("lw3", 35, 0, 3, n);
    cnt = 0;
    for (int i = 0; i < n; i++) if (seen[i].mem_req && seen[i].IorD) cnt++;
    chk("lw3_req_cycles", 32'(cnt), 32'd4);
    chk("lw3_memwb", 32'({seen[7].MemtoReg, seen[7].RegWrite, seen[7].RegDst}), 32'b110);
    cnt = 0;
    for (int i = 0; i < n; i++) if (seen[i].bus_err) cnt++;
    chk("lw3_no_buserr", 32'(cnt), 32'd0);

    do_instr("sw_to", 43, 0, 99, n);
    chk("sw_to_buserr15", 32'(seen[17].bus_err), 32'd1);
    chk("sw_to_buserr14", 32'(seen[16].bus_err), 32'd0);
    cnt = 0;
    for (int i = 0; i < n; i++) if (seen[i].MemWrite) cnt++;
    chk("sw_to_nowrite", 32'(cnt), 32'd0);

    do_instr("bne", 5, 0, 0, n);
    chk("bne_ctl", 32'({seen[2].Branch, seen[2].BranchNe, seen[2].ULAOp, seen[2].PCSrc}), 32'b0100101);
    do_instr("beq", 4, 0, 0, n);
    chk("beq_ctl", 32'({seen[2].Branch, seen[2].BranchNe, seen[2].ULAOp, seen[2].PCSrc}), 32'b1000101);

    do_instr("ori", 13, 0, 0, n);
    chk("ori_ex", 32'({seen[2].ULAOp, seen[2].ImmZext}), 32'b1001);
    chk("ori_wb", 32'({seen[3].ImmZext, seen[3].RegWrite, seen[3].RegDst}), 32'b110);

    do_instr("addi", 8, 0, 0, n);
    do_instr("slti", 10, 0, 0, n);
    do_instr("andi", 12, 0, 0, n);
    do_instr("j_fwait", 2, 2, 0, n);
    chk("fetch_wait_hold", 32'({seen[1].mem_req, seen[1].IRWrite, seen[2].IRWrite}), 32'b101);
    do_instr("lw14", 35, 0, 14, n);
    chk("lw14_ready_wins", 32'({seen[17].bus_err, seen[18].RegWrite}), 32'b01);
    do_instr("sw2", 43, 1, 2, n);
    cnt = 0;
    for (int i = 0; i < n; i++) if (seen[i].MemWrite) cnt++;
    chk("sw2_onewrite", 32'(cnt), 32'd1);

    do_instr("ill63", 63, 0, 0, n);
`ifdef MC_EXC_EN
    chk("exc_ctl", 32'({seen[2].exc_illegal, seen[2].PCWrite, seen[2].PCSrc}), 32'b1111);
`endif
    do_instr("after_ill", 0, 0, 0, n);

    // Reset during MEMREAD: request must vanish immediately, no enables.
    Opcode = 6'd35;
    w = '0; w.mem_req = 1'b1; w.ALUSrcB = 2'b01; w.IRWrite = 1'b1; w.PCWrite = 1'b1;
    push(1'b1, w);
    w = '0; w.ALUSrcB = 2'b11; push(1'b1, w);
    w = '0; w.ALUSrcA = 1'b1; w.ALUSrcB = 2'b10; push(1'b1, w);
    run_trace("pre_rst", n);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memread_req", 32'({mem_req, IorD}), 32'b11);
    mem_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({mem_req, IRWrite, PCWrite, MemWrite, RegWrite, bus_err}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_instr("post_rst", 0, 0, 0, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
